// File: rtl/pkt_check_pkg.sv
// pkt_check_pkg: shared types and constants for example_packet_checker.
//   state_t    - checker FSM states
//   err_code_t - per-frame error classes; lower value = higher priority
//   TKEEP_ALL  - the only legal tkeep on a 32-bit beat
package pkt_check_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SOP    = 2'd1,
    IN_PKT = 2'd2,
    DROP   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    KEEP       = 3'd1,
    IDX        = 3'd2,
    UPPER      = 3'd3,
    EARLY_LAST = 3'd4,
    NO_LAST    = 3'd5,
    TUSER      = 3'd6
  } err_code_t;

  localparam logic [3:0] TKEEP_ALL = 4'hF;

endpackage

// File: rtl/pkt_check_sat_counter.sv
// pkt_check_sat_counter: W-bit up-counter that sticks at all-ones.
//   m00_axis_aclk    - clock
//   m00_axis_aresetn - async active-low reset
//   clr              - synchronous clear, wins over inc
//   inc              - count one event
//   count            - current value
module pkt_check_sat_counter #(
  parameter int W = 32
) (
  input  logic         m00_axis_aclk,
  input  logic         m00_axis_aresetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/example_packet_checker.sv
// example_packet_checker: checks RX AXIS frames against the example packet
// generator pattern (tdata[15:0] = beat index, tdata[31:16] = constant word,
// tlast on index == length) and counts good/bad frames.
//   m00_axis_*       - RX stream (no tready; every valid beat is consumed)
//   expected_length  - index of the last beat, sampled on the SOP beat
//   expected_upper   - expected tdata[31:16], sampled on the SOP beat
//   clear_counters   - clears counts, last_err_code, err_sticky (and capture)
//   synced           - aligned to a frame boundary
//   pkt_start        - one-cycle pulse after an index-0 SOP beat
//   pkt_ok_count / pkt_err_count - saturating frame counters
//   last_err_code    - code of the most recent bad frame
//   err_sticky       - a bad frame has completed since reset/clear
// Optional: define PKT_CHECK_ERR_CAPTURE_EN to add err_capt_data and
// err_capt_exp_idx, holding tdata and expected index of the first bad beat.
//
// state  | meaning
// UNSYNC | waiting for any tlast to find a frame boundary
// SOP    | next valid beat is index 0 of a new frame
// IN_PKT | mid-frame, checking against exp_idx
// DROP   | frame already failed; discarding beats until tlast
module example_packet_checker
  import pkt_check_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int IDX_W = 16
) (
  input  logic             m00_axis_aclk,
  input  logic             m00_axis_aresetn,
  input  logic [31:0]      m00_axis_tdata,
  input  logic [3:0]       m00_axis_tkeep,
  input  logic             m00_axis_tvalid,
  input  logic             m00_axis_tlast,
  input  logic             m00_axis_tuser,
  input  logic [IDX_W-1:0] expected_length,
  input  logic [15:0]      expected_upper,
  input  logic             clear_counters,
  output logic             synced,
  output logic             pkt_start,
  output logic [CNT_W-1:0] pkt_ok_count,
  output logic [CNT_W-1:0] pkt_err_count,
  output logic [2:0]       last_err_code,
  output logic             err_sticky
`ifdef PKT_CHECK_ERR_CAPTURE_EN
  ,
  output logic [31:0]      err_capt_data,
  output logic [IDX_W-1:0] err_capt_exp_idx
`endif
);

  state_t           state;
  logic [IDX_W-1:0] exp_idx;
  logic [IDX_W-1:0] len_q;
  logic [15:0]      upper_q;
  err_code_t        code_q;

  logic [IDX_W-1:0] beat_idx;
  logic [IDX_W-1:0] chk_idx;
  logic [IDX_W-1:0] chk_len;
  logic [15:0]      chk_upper;
  err_code_t        beat_code;
  err_code_t        frame_code;
  logic             in_frame;
  logic             frame_end;
  logic             frame_ok;
  logic             frame_bad;

  assign beat_idx = m00_axis_tdata[IDX_W-1:0];
  assign in_frame = (state == SOP) || (state == IN_PKT);
  assign synced   = (state != UNSYNC);

  // On the SOP beat the length/pattern registers are being loaded this same
  // cycle, so the check uses the live inputs instead.
  always_comb begin
    chk_idx   = (state == SOP) ? '0 : exp_idx;
    chk_len   = (state == SOP) ? expected_length : len_q;
    chk_upper = (state == SOP) ? expected_upper : upper_q;
    beat_code = NONE;
    if (m00_axis_tkeep != TKEEP_ALL)
      beat_code = KEEP;
    else if (beat_idx != chk_idx)
      beat_code = IDX;
    else if (m00_axis_tdata[31:16] != chk_upper)
      beat_code = UPPER;
    else if (m00_axis_tlast && (chk_idx < chk_len))
      beat_code = EARLY_LAST;
    else if (!m00_axis_tlast && (chk_idx == chk_len))
      beat_code = NO_LAST;
    else if (m00_axis_tlast && m00_axis_tuser)
      beat_code = TUSER;
  end

  assign frame_end  = m00_axis_tvalid && m00_axis_tlast && (in_frame || (state == DROP));
  assign frame_code = (state == DROP) ? code_q : beat_code;
  assign frame_ok   = frame_end && (frame_code == NONE);
  assign frame_bad  = frame_end && (frame_code != NONE);

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state         <= UNSYNC;
      exp_idx       <= '0;
      len_q         <= '0;
      upper_q       <= '0;
      code_q        <= NONE;
      pkt_start     <= 1'b0;
      last_err_code <= 3'd0;
      err_sticky    <= 1'b0;
    end else begin
      pkt_start <= 1'b0;
      if (m00_axis_tvalid) begin
        case (state)
          UNSYNC: begin
            if (m00_axis_tlast) state <= SOP;
          end
          SOP, IN_PKT: begin
            if (state == SOP) begin
              len_q     <= expected_length;
              upper_q   <= expected_upper;
              pkt_start <= (beat_idx == '0);
            end
            if (beat_code != NONE) begin
              code_q  <= beat_code;
              exp_idx <= '0;
              state   <= m00_axis_tlast ? SOP : DROP;
            end else if (m00_axis_tlast) begin
              exp_idx <= '0;
              state   <= SOP;
            end else begin
              exp_idx <= chk_idx + 1'b1;
              state   <= IN_PKT;
            end
          end
          DROP: begin
            if (m00_axis_tlast) state <= SOP;
          end
          default: state <= UNSYNC;
        endcase
      end
      if (clear_counters) begin
        last_err_code <= 3'd0;
        err_sticky    <= 1'b0;
      end else if (frame_bad) begin
        last_err_code <= frame_code;
        err_sticky    <= 1'b1;
      end
    end
  end

  pkt_check_sat_counter #(.W(CNT_W)) u_ok_cnt (
    .m00_axis_aclk    (m00_axis_aclk),
    .m00_axis_aresetn (m00_axis_aresetn),
    .clr              (clear_counters),
    .inc              (frame_ok),
    .count            (pkt_ok_count)
  );

  pkt_check_sat_counter #(.W(CNT_W)) u_err_cnt (
    .m00_axis_aclk    (m00_axis_aclk),
    .m00_axis_aresetn (m00_axis_aresetn),
    .clr              (clear_counters),
    .inc              (frame_bad),
    .count            (pkt_err_count)
  );

`ifdef PKT_CHECK_ERR_CAPTURE_EN
  // Captures on the offending beat itself, which in DROP cases comes
  // several beats before the frame completes and err_sticky rises.
  logic capt_done;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      capt_done        <= 1'b0;
      err_capt_data    <= '0;
      err_capt_exp_idx <= '0;
    end else if (clear_counters) begin
      capt_done        <= 1'b0;
      err_capt_data    <= '0;
      err_capt_exp_idx <= '0;
    end else if (m00_axis_tvalid && in_frame && (beat_code != NONE) && !capt_done) begin
      capt_done        <= 1'b1;
      err_capt_data    <= m00_axis_tdata;
      err_capt_exp_idx <= chk_idx;
    end
  end
`endif

endmodule

// File: tb/tb_example_packet_checker.sv
module tb_example_packet_checker;

  localparam int CNT_W = 32;
  localparam int IDX_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      tdata = '0;
  logic [3:0]       tkeep = '0;
  logic             tvalid = 1'b0;
  logic             tlast = 1'b0;
  logic             tuser = 1'b0;
  logic [IDX_W-1:0] exp_length = '0;
  logic [15:0]      exp_upper = '0;
  logic             clear_counters = 1'b0;
  logic             synced;
  logic             pkt_start;
  logic [CNT_W-1:0] pkt_ok_count;
  logic [CNT_W-1:0] pkt_err_count;
  logic [2:0]       last_err_code;
  logic             err_sticky;
`ifdef PKT_CHECK_ERR_CAPTURE_EN
  logic [31:0]      err_capt_data;
  logic [IDX_W-1:0] err_capt_exp_idx;
`endif

  example_packet_checker #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .m00_axis_tdata   (tdata),
    .m00_axis_tkeep   (tkeep),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tlast   (tlast),
    .m00_axis_tuser   (tuser),
    .expected_length  (exp_length),
    .expected_upper   (exp_upper),
    .clear_counters   (clear_counters),
    .synced           (synced),
    .pkt_start        (pkt_start),
    .pkt_ok_count     (pkt_ok_count),
    .pkt_err_count    (pkt_err_count),
    .last_err_code    (last_err_code),
    .err_sticky       (err_sticky)
`ifdef PKT_CHECK_ERR_CAPTURE_EN
    ,
    .err_capt_data    (err_capt_data),
    .err_capt_exp_idx (err_capt_exp_idx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  // kind: 0 clean, 1 bad keep, 2 bad index, 3 bad upper, 4 early tlast,
  // 5 missing tlast (tlast two beats late), 6 tuser on last, 7 keep+index
  typedef struct {
    int          len;
    logic [15:0] up;
    int          kind;
    int          pos;
    logic [2:0]  code;
  } vec_t;

  beat_t       bq[$];
  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_start = 0;
  int          e_start = 0;
  logic [31:0] e_ok = '0;
  logic [31:0] e_err = '0;
  logic [2:0]  e_code = '0;
  logic        e_sticky = 1'b0;

  always @(negedge clk) if (pkt_start) n_start++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_synced);
    chk({tag, ".synced"}, 64'(synced), 64'(exp_synced));
    chk({tag, ".ok_count"}, 64'(pkt_ok_count), 64'(e_ok));
    chk({tag, ".err_count"}, 64'(pkt_err_count), 64'(e_err));
    chk({tag, ".last_err_code"}, 64'(last_err_code), 64'(e_code));
    chk({tag, ".err_sticky"}, 64'(err_sticky), 64'(e_sticky));
    chk({tag, ".pkt_start_pulses"}, 64'(n_start), 64'(e_start));
  endtask

  // Reference: walk the frame beat by beat, index i is what the beat should
  // carry; the first failing rule decides, and the frame ends at tlast.
  function automatic logic [2:0] model_code(input int len, input logic [15:0] up);
    for (int i = 0; i < bq.size(); i++) begin
      if (bq[i].keep != 4'hF) return 3'd1;
      if (bq[i].data[15:0] != 16'(i)) return 3'd2;
      if (bq[i].data[31:16] != up) return 3'd3;
      if (bq[i].last && (i < len)) return 3'd4;
      if (!bq[i].last && (i == len)) return 3'd5;
      if (bq[i].last && bq[i].user) return 3'd6;
      if (bq[i].last) return 3'd0;
    end
    return 3'd0;
  endfunction

  task automatic finish_frame(input logic [2:0] code, input bit clr);
    if (clr) begin
      e_ok = '0; e_err = '0; e_code = '0; e_sticky = 1'b0;
    end else if (code == 3'd0) begin
      if (e_ok != 32'hFFFF_FFFF) e_ok++;
    end else begin
      if (e_err != 32'hFFFF_FFFF) e_err++;
      e_code = code;
      e_sticky = 1'b1;
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    @(negedge clk);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tuser = u;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0; tdata = $urandom; tlast = 1'($urandom_range(0, 1));
      tuser = 1'b0; clear_counters = 1'b0;
    end
  endtask

  task automatic build_frame(input int len, input logic [15:0] up, input int kind, input int pos);
    beat_t b;
    int n;
    n = (kind == 4) ? pos + 1 : (kind == 5) ? len + 3 : len + 1;
    bq.delete();
    for (int i = 0; i < n; i++) begin
      b.data = {up, 16'(i)};
      b.keep = 4'hF;
      b.last = (i == n - 1);
      b.user = b.last ? (kind == 6) : 1'($urandom_range(0, 1));
      if (i == pos) begin
        case (kind)
          1: b.keep = 4'h7;
          2: b.data[15:0] = 16'(i + 5);
          3: b.data[31:16] = up ^ 16'h0100;
          7: begin b.keep = 4'h7; b.data[15:0] = 16'(i + 5); end
          default: ;
        endcase
      end
      bq.push_back(b);
    end
  endtask

  task automatic send_frame(input int len, input logic [15:0] up, input bit gaps,
                            input bit clr_last, input bit scramble);
    for (int i = 0; i < bq.size(); i++) begin
      if (gaps) idle_cycles($urandom_range(0, 2));
      @(negedge clk);
      if (i == 0) begin
        exp_length = IDX_W'(len);
        exp_upper = up;
      end else if (scramble) begin
        exp_length = IDX_W'($urandom_range(0, 15));
        exp_upper = 16'($urandom);
      end
      tvalid = 1'b1; tdata = bq[i].data; tkeep = bq[i].keep;
      tlast = bq[i].last; tuser = bq[i].user;
      clear_counters = clr_last && bq[i].last;
    end
    if (bq[0].data[15:0] == 16'h0) e_start++;
    idle_cycles(2);
  endtask

  initial begin
    int len, kind, pos;
    logic [15:0] up;
    logic [2:0] code;

    vecs.push_back('{7, 16'hA5A5, 0, 0, 3'd0});
    vecs.push_back('{7, 16'hA5A5, 0, 0, 3'd0});
    vecs.push_back('{7, 16'hA5A5, 0, 0, 3'd0});
    vecs.push_back('{7, 16'hA5A5, 2, 4, 3'd2});
    vecs.push_back('{7, 16'hA5A5, 0, 0, 3'd0});
    vecs.push_back('{7, 16'hA5A5, 4, 5, 3'd4});
    vecs.push_back('{7, 16'hA5A5, 5, 0, 3'd5});
    vecs.push_back('{7, 16'hA5A5, 6, 0, 3'd6});
    vecs.push_back('{7, 16'hA5A5, 7, 2, 3'd1});
    vecs.push_back('{0, 16'h1234, 0, 0, 3'd0});
    vecs.push_back('{0, 16'h1234, 5, 0, 3'd5});
    vecs.push_back('{3, 16'h00FF, 3, 1, 3'd3});
    vecs.push_back('{2, 16'hA5A5, 2, 0, 3'd2});
    vecs.push_back('{4, 16'h5A5A, 0, 0, 3'd0});

    repeat (3) @(negedge clk);
    chk("reset.pkt_start", 64'(pkt_start), 64'd0);
    check_all("reset", 1'b0);
    rst_n = 1'b1;

    // Unaligned traffic without tlast is ignored, then a stray tlast aligns.
    for (int i = 0; i < 3; i++) drive_beat($urandom, 4'hF, 1'b0, 1'b0);
    idle_cycles(2);
    check_all("pre_sync", 1'b0);
    drive_beat($urandom, 4'h3, 1'b1, 1'b1);
    idle_cycles(2);
    check_all("stray_tlast", 1'b1);

    foreach (vecs[v]) begin
      build_frame(vecs[v].len, vecs[v].up, vecs[v].kind, vecs[v].pos);
      send_frame(vecs[v].len, vecs[v].up, 1'b0, 1'b0, 1'b0);
      finish_frame(vecs[v].code, 1'b0);
      check_all($sformatf("vec%0d", v), 1'b1);
    end

    // Saturation of the OK counter.
    force u_dut.u_ok_cnt.count = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    release u_dut.u_ok_cnt.count;
    e_ok = 32'hFFFF_FFFF;
    build_frame(7, 16'hA5A5, 0, 0);
    send_frame(7, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    finish_frame(3'd0, 1'b0);
    check_all("saturate", 1'b1);

    // Clear coinciding with a completion: the clear wins both times.
    build_frame(5, 16'hC3C3, 2, 3);
    send_frame(5, 16'hC3C3, 1'b0, 1'b1, 1'b0);
    finish_frame(3'd2, 1'b1);
    check_all("clr_bad", 1'b1);
    build_frame(5, 16'hC3C3, 0, 0);
    send_frame(5, 16'hC3C3, 1'b0, 1'b1, 1'b0);
    finish_frame(3'd0, 1'b1);
    check_all("clr_ok", 1'b1);

    // Reset in the middle of a frame, then realign and recover.
    exp_length = 16'd7; exp_upper = 16'hA5A5;
    for (int i = 0; i < 4; i++) drive_beat({16'hA5A5, 16'(i)}, 4'hF, 1'b0, 1'b0);
    e_start++;
    @(negedge clk);
    tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e_ok = '0; e_err = '0; e_code = '0; e_sticky = 1'b0;
    check_all("mid_reset", 1'b0);
    for (int i = 4; i < 8; i++) drive_beat({16'hA5A5, 16'(i)}, 4'hF, i == 7, 1'b0);
    idle_cycles(2);
    check_all("realign", 1'b1);
    build_frame(7, 16'hA5A5, 0, 0);
    send_frame(7, 16'hA5A5, 1'b1, 1'b0, 1'b0);
    finish_frame(3'd0, 1'b0);
    check_all("gapped_ok", 1'b1);

    // Random frames against the reference model.
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(0, 7);
      up = 16'($urandom);
      kind = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 7);
      if (kind == 4 && len == 0) kind = 0;
      pos = (kind == 4) ? $urandom_range(0, len - 1) : $urandom_range(0, len);
      build_frame(len, up, kind, pos);
      code = model_code(len, up);
      send_frame(len, up, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      finish_frame(code, 1'b0);
      check_all($sformatf("rand%0d", f), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
